// File: rtl/disp_dat_arbiter.sv
// Round-robin arbiter sharing the display-data register between the host bus and the pattern source.
// A granted word is held pending and committed only on a frame strobe, so frames never tear.
module disp_dat_arbiter #(
    parameter int              C_DW         = 16,
    parameter int              C_MIN_FRAMES = 2,
    parameter logic [C_DW-1:0] C_RST_DAT    = '0
) (
    input  logic            CK_i,
    input  logic            XARST_i,
    input  logic            PX_CK_EE_i,
    input  logic            VSYNC_EE_i,
    input  logic            REQ0_i,
    input  logic [C_DW-1:0] DAT0s_i,
    output logic            ACK0_o,
    input  logic            REQ1_i,
    input  logic [C_DW-1:0] DAT1s_i,
    output logic            ACK1_o,
    output logic [C_DW-1:0] DISP_DATss_o,
    output logic            PEND_o,
    output logic            COMMIT_o
);

    localparam int CW = (C_MIN_FRAMES > 1) ? $clog2(C_MIN_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(C_MIN_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, WAIT_VB, HOLD} state_t;

    state_t          state, state_nxt;
    logic            last, last_nxt;
    logic [CW-1:0]   cnt, cnt_nxt, cnt_inc;
    logic [C_DW-1:0] pend_dat;
    logic            fs, grant0, grant1, commit;

    assign fs      = VSYNC_EE_i & PX_CK_EE_i;
    assign cnt_inc = cnt + CW'(1);
    assign PEND_o  = (state == WAIT_VB);

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        cnt_nxt   = cnt;
        grant0    = 1'b0;
        grant1    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the requester that did not win last time takes it.
                if (REQ0_i && (!REQ1_i || last)) begin
                    grant0    = 1'b1;
                    last_nxt  = 1'b0;
                    state_nxt = WAIT_VB;
                end else if (REQ1_i) begin
                    grant1    = 1'b1;
                    last_nxt  = 1'b1;
                    state_nxt = WAIT_VB;
                end
            end
            WAIT_VB: begin
                // A strobe landing on the ACK cycle is too early; wait for the next one.
                if (fs && !(ACK0_o || ACK1_o)) begin
                    commit    = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = (C_MIN_FRAMES > 1) ? HOLD : IDLE;
                end
            end
            HOLD: begin
                if (fs) begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == CNT_LAST)
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            state        <= IDLE;
            last         <= 1'b1;
            cnt          <= '0;
            ACK0_o       <= 1'b0;
            ACK1_o       <= 1'b0;
            COMMIT_o     <= 1'b0;
            pend_dat     <= C_RST_DAT;
            DISP_DATss_o <= C_RST_DAT;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            cnt      <= cnt_nxt;
            ACK0_o   <= grant0;
            ACK1_o   <= grant1;
            COMMIT_o <= commit;
            if (grant0)
                pend_dat <= DAT0s_i;
            else if (grant1)
                pend_dat <= DAT1s_i;
            if (commit)
                DISP_DATss_o <= pend_dat;
        end
    end

endmodule

// File: tb/tb_disp_dat_arbiter.sv
// Directed bench for disp_dat_arbiter (C_MIN_FRAMES=2): grants, commits, frame gating and reset.
module tb_disp_dat_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        px = 1'b1;
    logic        vs = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [15:0] dat0 = '0, dat1 = '0;
    logic        ack0, ack1, pend, commit;
    logic [15:0] disp;

    int total = 0;
    int bad   = 0;

    disp_dat_arbiter #(.C_DW(16), .C_MIN_FRAMES(2), .C_RST_DAT(16'h0000)) dut (
        .CK_i(clk), .XARST_i(rst_n), .PX_CK_EE_i(px), .VSYNC_EE_i(vs),
        .REQ0_i(req0), .DAT0s_i(dat0), .ACK0_o(ack0),
        .REQ1_i(req1), .DAT1s_i(dat1), .ACK1_o(ack1),
        .DISP_DATss_o(disp), .PEND_o(pend), .COMMIT_o(commit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle frame strobe; returns just after the edge that samples it.
    task automatic frame();
        vs = 1'b1;
        tick();
        vs = 1'b0;
    endtask

    initial begin
        // reset state
        tick(2);
        chk("rst_disp", disp, 16'h0000);
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_pend", pend, 0);
        chk("rst_commit", commit, 0);
        rst_n = 1'b1;
        tick();

        // single uncontended request
        req0 = 1'b1; dat0 = 16'hA55A;
        tick();
        chk("t1_ack0", ack0, 1);
        chk("t1_pend", pend, 1);
        chk("t1_disp_pre", disp, 16'h0000);
        req0 = 1'b0;
        tick();
        chk("t1_ack0_drop", ack0, 0);
        tick(20);
        chk("t1_no_commit", commit, 0);
        frame();
        chk("t1_commit", commit, 1);
        chk("t1_disp", disp, 16'hA55A);
        tick();
        chk("t1_commit_pulse", commit, 0);
        chk("t1_pend_clr", pend, 0);

        // round robin from a fresh reset (req0 wins first tie)
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        dat0 = 16'h1111; dat1 = 16'h2222; req0 = 1'b1; req1 = 1'b1;
        tick();
        chk("t2_g1_ack0", ack0, 1);
        chk("t2_g1_ack1", ack1, 0);
        req0 = 1'b0;
        tick();
        req0 = 1'b1;
        tick(3);
        frame();
        chk("t2_c1", commit, 1);
        chk("t2_c1_disp", disp, 16'h1111);
        tick(3);
        frame();
        chk("t2_hold_no_commit", commit, 0);
        tick();
        chk("t2_g2_ack1", ack1, 1);
        chk("t2_g2_ack0", ack0, 0);
        req1 = 1'b0;
        tick(3);
        frame();
        chk("t2_c2", commit, 1);
        chk("t2_c2_disp", disp, 16'h2222);
        tick(3);
        frame();
        tick();
        chk("t2_g3_ack0", ack0, 1);
        chk("t2_g3_ack1", ack1, 0);
        req0 = 1'b0;
        tick(3);
        frame();
        chk("t2_c3", commit, 1);
        chk("t2_c3_disp", disp, 16'h1111);

        // strobe without pixel enable: no frame counted, no commit
        req1 = 1'b1; dat1 = 16'h4444; vs = 1'b1; px = 1'b0;
        tick();
        vs = 1'b0; px = 1'b1;
        tick();
        chk("t3_hold_no_ack", ack1, 0);
        tick();
        chk("t3_hold_no_ack2", ack1, 0);
        frame();
        tick();
        chk("t3_ack1", ack1, 1);
        req1 = 1'b0;
        tick();
        vs = 1'b1; px = 1'b0;
        tick();
        chk("t3_gated_commit", commit, 0);
        chk("t3_gated_disp", disp, 16'h1111);
        px = 1'b1;
        tick();
        vs = 1'b0;
        chk("t3_commit", commit, 1);
        chk("t3_disp", disp, 16'h4444);

        // strobe coinciding with the grant and ACK cycles is ignored
        tick(2);
        frame();
        tick();
        req0 = 1'b1; dat0 = 16'h5555; vs = 1'b1;
        tick();
        chk("t4_ack0", ack0, 1);
        chk("t4_no_commit_grant", commit, 0);
        req0 = 1'b0;
        tick();
        vs = 1'b0;
        chk("t4_no_commit_ack", commit, 0);
        chk("t4_disp_hold", disp, 16'h4444);
        chk("t4_pend", pend, 1);
        tick(2);
        frame();
        chk("t4_commit", commit, 1);
        chk("t4_disp", disp, 16'h5555);

        // request withdrawn while in HOLD
        req1 = 1'b1; dat1 = 16'h6666;
        tick(2);
        req1 = 1'b0;
        tick();
        frame();
        tick(2);
        chk("t5_no_ack1", ack1, 0);
        chk("t5_pend", pend, 0);
        chk("t5_disp", disp, 16'h5555);
        chk("t5_commit", commit, 0);

        // reset while a word is pending
        req0 = 1'b1; dat0 = 16'hBEEF;
        tick();
        chk("t6_ack0", ack0, 1);
        tick();
        chk("t6_pend", pend, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_disp", disp, 16'h0000);
        chk("t6_rst_pend", pend, 0);
        chk("t6_rst_ack0", ack0, 0);
        tick();
        rst_n = 1'b1; vs = 1'b1;
        tick();
        vs = 1'b0;
        chk("t6_reack0", ack0, 1);
        chk("t6_no_commit", commit, 0);
        chk("t6_disp_after", disp, 16'h0000);
        req0 = 1'b0;
        tick(2);
        frame();
        chk("t6_commit", commit, 1);
        chk("t6_disp_beef", disp, 16'hBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/disp_dat_arbiter.md
Name: disp_dat_arbiter

Overview:
- Shares the 16-bit display-data input of the NTSC square-font video core between two writers.
  - Requester 0 is the host register bus (R9/R8 data).
  - Requester 1 is the on-chip pattern/LFSR source.
- Round-robin grant with a request/acknowledge handshake; the granted word is held pending.
- The pending word is committed to the display register only at a frame-start strobe, so a frame never tears.
- Enforces a minimum number of frames each committed word stays on screen.

Parameters:
- C_DW, 16, display data width in bits.
- C_MIN_FRAMES, 2, minimum frame strobes between successive commits (legal range 1..255).
- C_RST_DAT, 16'h0000, value of DISP_DATss_o after reset.

Ports:
- CK_i  in  1  system clock (n x 12.27272 MHz).
- XARST_i  in  1  reset, asynchronous, active-low.
- PX_CK_EE_i  in  1  pixel-clock enable from the video core.
- VSYNC_EE_i  in  1  frame-start strobe, one CK wide; effective only when PX_CK_EE_i=1.
- REQ0_i  in  1  requester 0 write request (level).
- DAT0s_i  in  C_DW  requester 0 data.
- ACK0_o  out  1  one-cycle grant/accept pulse to requester 0.
- REQ1_i  in  1  requester 1 write request (level).
- DAT1s_i  in  C_DW  requester 1 data.
- ACK1_o  out  1  one-cycle grant/accept pulse to requester 1.
- DISP_DATss_o  out  C_DW  committed display data to the video core.
- PEND_o  out  1  a word is accepted and waiting for a frame strobe.
- COMMIT_o  out  1  one-cycle pulse on the cycle DISP_DATss_o updates.

Behaviour:
- Reset values:
  - DISP_DATss_o=C_RST_DAT.
  - ACK0_o, ACK1_o, PEND_o, COMMIT_o all 0.
  - State IDLE, frame counter 0, round-robin pointer LAST=1 (requester 0 wins first tie).
- A frame strobe (FS) is VSYNC_EE_i & PX_CK_EE_i. The arbiter itself runs every CK.
- States:
  - IDLE:
    - If REQ0_i|REQ1_i: pick the winner. If only one requests, it wins; if both request, the one != LAST wins.
    - Capture the winner's DATs_i into PENDs, pulse its ACK for exactly 1 cycle, set LAST=winner, go to WAIT_VB.
    - An FS in the same cycle as a grant is ignored; the commit waits for the next FS.
  - WAIT_VB: PEND_o=1; no grants are issued. On FS:
    - DISP_DATss_o<=PENDs and COMMIT_o=1 in the same registered cycle.
    - Frame counter <=0.
    - Go to HOLD if C_MIN_FRAMES>1, else IDLE.
  - HOLD: no grants. Each FS increments the counter; the FS that makes the counter =C_MIN_FRAMES-1 moves to IDLE.
    - Net effect: after a commit on FS number F, the next commit occurs no earlier than FS number F+C_MIN_FRAMES.
- Handshake rules:
  - A requester holds REQ and DAT stable until its ACK.
  - ACK is registered, asserted the cycle after IDLE samples the request, and the data is sampled in that same cycle.
  - A requester may drop REQ before ACK, which withdraws the request; no ACK is then issued.
  - A requester must deassert REQ the cycle after ACK; if REQ is still high, it is a new request.
- ACK0_o and ACK1_o are never high together. At most one word is pending; no queue exists.
- Latency: an uncontended request in IDLE gives ACK at +1 CK; commit happens at the first FS strictly after the ACK cycle.
- Counter width: ceil(log2(C_MIN_FRAMES)) bits, min 1; it never wraps (reset to 0 on every commit).
- Reset asserted mid-operation: state, pending word and outputs return to reset values immediately. The pending word is lost, no ACK or COMMIT is issued, and a requester still holding REQ is re-arbitrated after release.
- DISP_DATss_o changes only on COMMIT_o cycles.

Test Plan:
- Reset, then REQ0=1 with DAT0=16'hA55A, FS every 1000 CK -> ACK0 pulse at +1 CK, PEND_o=1, DISP_DATss_o=16'hA55A with COMMIT_o on the first FS after the ACK, 16'h0000 before it.
- REQ0 and REQ1 asserted in the same cycle (DAT0=16'h1111, DAT1=16'h2222), both re-requested after their ACKs -> grant order req0, req1, req0. Commits are 16'h1111, 16'h2222, ... spaced exactly 2 FS apart (C_MIN_FRAMES=2).
- VSYNC_EE_i pulsed while PX_CK_EE_i=0 -> no commit and no counter change. The same pulse with PX_CK_EE_i=1 -> commit.
- Grant cycle coincides with FS -> no commit on that FS; commit on the next FS.
- REQ1 raised, then dropped before ACK while the block is in HOLD -> no ACK1, DISP_DATss_o unchanged, returns to IDLE with PEND_o=0.
- XARST_i pulsed low in WAIT_VB with pending 16'hBEEF -> DISP_DATss_o=16'h0000 and PEND_o=0 immediately. No COMMIT on the following FS; a still-high REQ0 is ACKed 1 CK after release.
